mem_port_arbiter: RTL and testbench

//  Shares the single-port byte-readable word memory (6-bit word address, 2-bit byte select,
//  mem_write strobe, 8-bit byte read-back) between two requesters.

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin front end for a single-port byte-readable word memory.
// One access in flight: address/strobe phase, read-latency wait, read-data capture, ack.
module mem_port_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       we0,
    input  logic [5:0] addr0,
    input  logic [1:0] bsel0,
    input  logic       req1,
    input  logic       we1,
    input  logic [5:0] addr1,
    input  logic [1:0] bsel1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [5:0] mem_arr,
    output logic [1:0] mem_sw,
    output logic       mem_write,
    input  logic [7:0] mem_led
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic        we_q, we_d;
    logic [5:0]  addr_q, addr_d;
    logic [1:0]  bsel_q, bsel_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            bsel_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            bsel_q     <= bsel_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        bsel_d     = bsel_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        // On a tie the requester that did not win last time gets the port.
        pick       = (req0 && req1) ? ~last_gnt_q : req1;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    we_d       = pick ? we1   : we0;
                    addr_d     = pick ? addr1 : addr0;
                    bsel_d     = pick ? bsel1 : bsel0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = 3'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_led;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe is decoded from state so an async reset removes it in the same cycle.
    assign mem_write = (state_q == ACCESS) && we_q;
    assign ack0      = (state_q == DONE) && !gnt_q;
    assign ack1      = (state_q == DONE) && gnt_q;
    assign busy      = (state_q != IDLE);
    assign mem_arr   = addr_q;
    assign mem_sw    = bsel_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a small behavioural memory whose write data comes from sw_data.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_data;

    logic       req0, we0, req1, we1;
    logic [5:0] addr0, addr1;
    logic [1:0] bsel0, bsel1;
    logic       ack0, ack1, busy, mem_write;
    logic [7:0] rdata, mem_led;
    logic [5:0] mem_arr;
    logic [1:0] mem_sw;

    logic       b_req0, b_we0;
    logic [5:0] b_addr0;
    logic [1:0] b_bsel0;
    logic       b_ack0, b_ack1, b_busy, b_mem_write;
    logic [7:0] b_rdata, b_mem_led;
    logic [5:0] b_mem_arr;
    logic [1:0] b_mem_sw;

    logic [7:0] mem1 [0:63][0:3];
    logic [7:0] mem3 [0:63][0:3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .bsel0(bsel0),
        .req1(req1), .we1(we1), .addr1(addr1), .bsel1(bsel1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_arr(mem_arr), .mem_sw(mem_sw), .mem_write(mem_write), .mem_led(mem_led)
    );

    mem_port_arbiter #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .bsel0(b_bsel0),
        .req1(1'b0), .we1(1'b0), .addr1(6'h00), .bsel1(2'b00),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
        .mem_arr(b_mem_arr), .mem_sw(b_mem_sw), .mem_write(b_mem_write), .mem_led(b_mem_led)
    );

    always @(posedge clk) begin
        if (mem_write) mem1[mem_arr][mem_sw] <= sw_data;
        if (b_mem_write) mem3[b_mem_arr][b_mem_sw] <= sw_data;
    end
    assign mem_led   = mem1[mem_arr][mem_sw];
    assign b_mem_led = mem3[b_mem_arr][b_mem_sw];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        int   acks;
        int   both;
        int   lat;
        int   seq [4];
        logic pend0, pend1;

        rst_n = 1'b0; sw_data = 8'h00;
        req0 = 0; we0 = 0; addr0 = 0; bsel0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; bsel1 = 0;
        b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_bsel0 = 0;

        // 1: reset state, then 10 idle cycles
        tick; tick;
        chk("rst_outs", {ack0, ack1, busy, mem_write, mem_arr, mem_sw, rdata}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_outs", {ack0, ack1, busy, mem_write, mem_arr, mem_sw, rdata}, 32'h0);
        end

        // 2: write from requester 0
        sw_data = 8'h5A; req0 = 1; we0 = 1; addr0 = 6'h05; bsel0 = 2'd2;
        tick;
        chk("wr_strobe", {mem_write, mem_arr, mem_sw}, {1'b1, 6'h05, 2'd2});
        chk("wr_ack_early", ack0, 0);
        addr0 = 6'h07; bsel0 = 2'd1;
        tick;
        chk("wr_ack", {ack0, ack1}, 2'b10);
        chk("wr_strobe_off", mem_write, 0);
        chk("wr_addr_held", {mem_arr, mem_sw}, {6'h05, 2'd2});
        chk("wr_rdata_same", rdata, 8'h00);
        req0 = 0;
        tick;
        chk("wr_after", {ack0, busy}, 2'b00);

        // 3: preload byte A5 at 0/3 through requester 1, then read it back
        sw_data = 8'hA5; req1 = 1; we1 = 1; addr1 = 6'h00; bsel1 = 2'd3;
        tick; tick;
        chk("pre_ack", ack1, 1);
        req1 = 0;
        tick;
        sw_data = 8'h00; req1 = 1; we1 = 0;
        tick;
        chk("rd_access", {busy, mem_write, ack1}, 3'b100);
        tick;
        chk("rd_wait", {mem_write, ack1}, 2'b00);
        tick;
        chk("rd_ack", {ack0, ack1, mem_write}, 3'b010);
        chk("rd_data", rdata, 8'hA5);
        req1 = 0;
        tick;

        // 4: contention with both requests held from reset
        rst_n = 1'b0;
        req0 = 1; we0 = 1; addr0 = 6'h10; bsel0 = 0;
        req1 = 1; we1 = 1; addr1 = 6'h20; bsel1 = 1;
        tick;
        rst_n = 1'b1;
        acks = 0; both = 0; pend0 = 0; pend1 = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            tick;
            if (pend0) begin req0 = 1; pend0 = 0; end
            if (pend1) begin req1 = 1; pend1 = 0; end
            if (ack0 && ack1) both++;
            if (ack0) begin seq[acks] = 0; acks++; req0 = 0; pend0 = 1; end
            else if (ack1) begin seq[acks] = 1; acks++; req1 = 0; pend1 = 1; end
        end
        req0 = 0; req1 = 0;
        chk("rr_count", acks, 4);
        chk("rr_both", both, 0);
        for (int k = 0; k < 4 && k < acks; k++)
            chk($sformatf("rr_gnt%0d", k), seq[k], k % 2);
        tick;
        chk("rr_idle", busy, 0);

        // 5: reset during WAIT of a read, and during a write strobe
        req1 = 1; we1 = 0; addr1 = 6'h00; bsel1 = 2'd3;
        tick; tick;
        chk("mid_wait_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {ack0, ack1, busy, mem_write, mem_arr, mem_sw, rdata}, 32'h0);
        req1 = 0;
        tick;
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (ack0 || ack1) acks++;
        end
        chk("mid_no_ack", acks, 0);
        req0 = 1; we0 = 1; addr0 = 6'h09; bsel0 = 0;
        tick;
        chk("mid_wr_strobe", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_wr_drop", mem_write, 0);
        req0 = 0;
        tick;
        rst_n = 1'b1;
        tick;
        req1 = 1; we1 = 0; addr1 = 6'h00; bsel1 = 2'd3;
        tick; tick; tick;
        chk("post_rst_ack", {ack0, ack1}, 2'b01);
        chk("post_rst_data", rdata, 8'hA5);
        req1 = 0;
        tick;

        // 6: boundary address/select on the RD_LAT=3 instance
        sw_data = 8'h3C; b_req0 = 1; b_we0 = 1; b_addr0 = 6'h3F; b_bsel0 = 2'b11;
        tick;
        chk("bd_strobe", {b_mem_write, b_mem_arr, b_mem_sw}, {1'b1, 6'h3F, 2'b11});
        tick;
        chk("bd_wr_ack", b_ack0, 1);
        b_req0 = 0;
        tick;
        sw_data = 8'hFF; b_req0 = 1; b_we0 = 0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick;
            if (b_mem_write) chk("bd_rd_nostrobe", b_mem_write, 0);
            if (b_ack0) lat = i;
        end
        b_req0 = 0;
        chk("bd_rd_lat", lat, 5);
        chk("bd_rd_data", b_rdata, 8'h3C);
        tick;
        chk("bd_idle", {b_busy, b_ack0, b_ack1}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
